// File: rtl/demux32_buf_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | demux32_buf_if : source/sink handshake bundle for demux32_buf               |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
interface demux32_buf_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic [WIDTH-1:0] in;
    logic             s;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out1;
    logic             out1_valid;
    logic             out1_ready;
    logic [WIDTH-1:0] out2;
    logic             out2_valid;
    logic             out2_ready;
    logic [CNT_W-1:0] cnt1;
    logic [CNT_W-1:0] cnt2;

    modport master (
        output in, s, in_valid, out1_ready, out2_ready,
        input  in_ready, out1, out1_valid, out2, out2_valid, cnt1, cnt2
    );

    modport slave (
        input  in, s, in_valid, out1_ready, out2_ready,
        output in_ready, out1, out1_valid, out2, out2_valid, cnt1, cnt2
    );
endinterface
`default_nettype wire

// File: rtl/demux32_buf.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | demux32_buf : 1-to-2 demultiplexer with a 2-entry FIFO and a saturating     |
// |               accepted-word counter per output channel                      |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module demux32_buf #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    demux32_buf_if.slave  bus
);

    localparam logic [1:0] C_OCC_EMPTY = 2'd0;
    localparam logic [1:0] C_OCC_ONE   = 2'd1;
    localparam logic [1:0] C_OCC_FULL  = 2'd2;

    // Index 0 is channel 1, index 1 is channel 2. head holds the oldest entry.
    logic [WIDTH-1:0] head_q [2];
    logic [WIDTH-1:0] head_d [2];
    logic [WIDTH-1:0] tail_q [2];
    logic [WIDTH-1:0] tail_d [2];
    logic [1:0]       occ_q  [2];
    logic [1:0]       occ_d  [2];
    logic [CNT_W-1:0] cnt_q  [2];
    logic [CNT_W-1:0] cnt_d  [2];

    logic [1:0] w_sel_occ;
    logic       w_in_ready;
    logic [1:0] w_push;
    logic [1:0] w_pop;
    logic [1:0] w_out_ready;

    always_comb begin
        w_out_ready = {bus.out2_ready, bus.out1_ready};
        w_sel_occ   = bus.s ? occ_q[1] : occ_q[0];
        // Readiness depends only on stored occupancy so a full channel never
        // accepts in the same cycle it drains.
        w_in_ready  = rst_n && (w_sel_occ != C_OCC_FULL);
        w_push[0]   = bus.in_valid && w_in_ready && !bus.s;
        w_push[1]   = bus.in_valid && w_in_ready &&  bus.s;
        w_pop[0]    = rst_n && (occ_q[0] != C_OCC_EMPTY) && w_out_ready[0];
        w_pop[1]    = rst_n && (occ_q[1] != C_OCC_EMPTY) && w_out_ready[1];
    end

    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            head_d[ch] = head_q[ch];
            tail_d[ch] = tail_q[ch];
            occ_d[ch]  = occ_q[ch];
            cnt_d[ch]  = cnt_q[ch];

            case (occ_q[ch])
                C_OCC_EMPTY: begin
                    if (w_push[ch]) begin
                        head_d[ch] = bus.in;
                        occ_d[ch]  = C_OCC_ONE;
                    end
                end
                C_OCC_ONE: begin
                    if (w_push[ch] && w_pop[ch]) begin
                        head_d[ch] = bus.in;
                    end else if (w_push[ch]) begin
                        tail_d[ch] = bus.in;
                        occ_d[ch]  = C_OCC_FULL;
                    end else if (w_pop[ch]) begin
                        // head keeps the departed word so the output holds its last value
                        occ_d[ch]  = C_OCC_EMPTY;
                    end
                end
                default: begin
                    if (w_pop[ch]) begin
                        head_d[ch] = tail_q[ch];
                        occ_d[ch]  = C_OCC_ONE;
                    end
                end
            endcase

            if (w_push[ch] && (cnt_q[ch] != {CNT_W{1'b1}})) begin
                cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int ch = 0; ch < 2; ch++) begin
                head_q[ch] <= '0;
                tail_q[ch] <= '0;
                occ_q[ch]  <= C_OCC_EMPTY;
                cnt_q[ch]  <= '0;
            end
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                head_q[ch] <= head_d[ch];
                tail_q[ch] <= tail_d[ch];
                occ_q[ch]  <= occ_d[ch];
                cnt_q[ch]  <= cnt_d[ch];
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out1       = head_q[0];
    assign bus.out1_valid = (occ_q[0] != C_OCC_EMPTY);
    assign bus.out2       = head_q[1];
    assign bus.out2_valid = (occ_q[1] != C_OCC_EMPTY);
    assign bus.cnt1       = cnt_q[0];
    assign bus.cnt2       = cnt_q[1];

endmodule
`default_nettype wire

// File: tb/tb_demux32_buf.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_demux32_buf : directed and random stimulus against a queue-based model   |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module tb_demux32_buf;

    localparam int WIDTH   = 32;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    demux32_buf_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    demux32_buf #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference model: one FIFO queue, counter and last-shown word per channel.
    logic [WIDTH-1:0] q1[$];
    logic [WIDTH-1:0] q2[$];
    int               c1, c2;
    logic [WIDTH-1:0] last1, last2;
    bit               accepted;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check in_ready before the edge, advance the model, check outputs after.
    task automatic tick();
        bit         exp_ready, push, p1, p2, sel;
        logic [WIDTH-1:0] din;
        #1;
        sel       = bus.s;
        din       = bus.in;
        exp_ready = rst_n && ((sel ? q2.size() : q1.size()) < 2);
        chk("in_ready", {63'd0, bus.in_ready}, {63'd0, exp_ready});
        push     = bus.in_valid && exp_ready;
        accepted = push;
        p1       = rst_n && (q1.size() != 0) && bus.out1_ready;
        p2       = rst_n && (q2.size() != 0) && bus.out2_ready;
        @(posedge clk);
        if (!rst_n) begin
            q1.delete();
            q2.delete();
            c1 = 0;
            c2 = 0;
            last1 = '0;
            last2 = '0;
        end else begin
            if (p1) void'(q1.pop_front());
            if (p2) void'(q2.pop_front());
            if (push) begin
                if (sel) begin
                    q2.push_back(din);
                    if (c2 < CNT_MAX) c2++;
                end else begin
                    q1.push_back(din);
                    if (c1 < CNT_MAX) c1++;
                end
            end
            if (q1.size() != 0) last1 = q1[0];
            if (q2.size() != 0) last2 = q2[0];
        end
        #1;
        chk("out1_valid", {63'd0, bus.out1_valid}, {63'd0, q1.size() != 0});
        chk("out2_valid", {63'd0, bus.out2_valid}, {63'd0, q2.size() != 0});
        chk("out1", 64'(bus.out1), 64'(last1));
        chk("out2", 64'(bus.out2), 64'(last2));
        chk("cnt1", 64'(bus.cnt1), 64'(c1));
        chk("cnt2", 64'(bus.cnt2), 64'(c2));
    endtask

    // Present a word and hold it until accepted; n returns the cycles taken.
    task automatic send(input logic [WIDTH-1:0] data, input logic sel, output int n);
        bus.in       = data;
        bus.s        = sel;
        bus.in_valid = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!accepted && n < 20);
        if (!accepted) chk("send_timeout", 64'(n), 64'(0));
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int cycles);
        bus.in_valid = 1'b0;
        repeat (cycles) tick();
    endtask

    initial begin
        int n;
        rst_n          = 1'b0;
        bus.in         = '0;
        bus.s          = 1'b0;
        bus.in_valid   = 1'b1;
        bus.out1_ready = 1'b1;
        bus.out2_ready = 1'b1;
        c1 = 0; c2 = 0; last1 = '0; last2 = '0;

        // Reset: in_ready must stay low even with in_valid asserted.
        tick();
        tick();
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        tick();

        // Single word into channel 1, sink stalled.
        bus.out1_ready = 1'b0;
        send(32'h0000_00AA, 1'b0, n);
        chk("first_out1", 64'(bus.out1), 64'h0000_00AA);
        bus.out1_ready = 1'b1;
        idle(2);

        // Backpressure on channel 2.
        bus.out2_ready = 1'b0;
        send(32'h11, 1'b1, n);
        send(32'h22, 1'b1, n);
        bus.in       = 32'h33;
        bus.in_valid = 1'b1;
        tick();
        chk("bp_third_rejected", {63'd0, accepted}, 64'd0);
        bus.out2_ready = 1'b1;
        send(32'h33, 1'b1, n);
        idle(3);
        chk("bp_cnt2", 64'(bus.cnt2), 64'd3);

        // Full channel with a pop in the same cycle: accepted one cycle later.
        bus.out1_ready = 1'b0;
        send(32'hA1, 1'b0, n);
        send(32'hA2, 1'b0, n);
        bus.out1_ready = 1'b1;
        send(32'hA3, 1'b0, n);
        chk("full_pop_wait", 64'(n), 64'd2);
        idle(3);

        // Cross traffic: pop channel 2 while pushing channel 1.
        bus.out2_ready = 1'b0;
        send(32'h77, 1'b1, n);
        bus.out2_ready = 1'b1;
        bus.out1_ready = 1'b0;
        send(32'h55, 1'b0, n);
        chk("cross_out1", 64'(bus.out1), 64'h55);
        chk("cross_out2_valid", {63'd0, bus.out2_valid}, 64'd0);
        bus.out1_ready = 1'b1;
        idle(2);

        // Counter saturation on channel 1.
        for (int i = 0; i < 17; i++) send(32'h100 + i, 1'b0, n);
        idle(2);
        chk("sat_cnt1", 64'(bus.cnt1), 64'(CNT_MAX));

        // Reset with both channels full.
        bus.out1_ready = 1'b0;
        bus.out2_ready = 1'b0;
        send(32'hB1, 1'b0, n);
        send(32'hB2, 1'b0, n);
        send(32'hC1, 1'b1, n);
        send(32'hC2, 1'b1, n);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.s = 1'b0;
        tick();
        chk("post_rst_cnt1", 64'(bus.cnt1), 64'd0);

        // Random traffic, rare resets.
        for (int i = 0; i < 400; i++) begin
            bus.in         = $urandom;
            bus.s          = 1'($urandom_range(0, 1));
            bus.in_valid   = ($urandom_range(0, 3) != 0);
            bus.out1_ready = ($urandom_range(0, 2) != 0);
            bus.out2_ready = ($urandom_range(0, 2) != 0);
            rst_n          = ($urandom_range(0, 99) != 0);
            tick();
        end
        rst_n = 1'b1;
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
